// File: rtl/nmea_sentence_tx_if.sv
// Byte-stream handshakes around the NMEA sentence framer: payload input and UART TX request/done.
interface nmea_sentence_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;

    // master: payload producer plus UART transmitter; slave: the framer
    modport master (
        output in_data, in_valid, in_last, tx_done,
        input  in_ready, tx_data, tx_start
    );

    modport slave (
        input  in_data, in_valid, in_last, tx_done,
        output in_ready, tx_data, tx_start
    );
endinterface

// File: rtl/nmea_sentence_tx.sv
// Frames a raw NMEA payload stream as "$<payload>*hh\r\n" and feeds it byte by byte to the UART
// transmitter through its start/done handshake.
module nmea_sentence_tx #(
    parameter int unsigned MAX_PAYLOAD = 76,
    parameter int unsigned LEN_BITS    = 7
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    nmea_sentence_tx_if.slave bus,
    output logic              busy,
    output logic              sentence_done,
    output logic              err_overlong,
    output logic              err_char
);

    typedef enum logic [4:0] {
        StIdle, StSendSof, StWaitSof, StPayIn, StSendPay, StWaitPay, StDrop,
        StSendStar, StWaitStar, StSendHi, StWaitHi, StSendLo, StWaitLo,
        StSendCr, StWaitCr, StSendLf, StWaitLf
    } state_e;

    localparam logic [LEN_BITS-1:0] MaxLen = LEN_BITS'(MAX_PAYLOAD);

    state_e              state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [7:0]          csum_q, csum_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                last_q, last_d;
    logic                trunc_q, trunc_d;
    logic                in_ready;
    logic                tx_start;
    logic [LEN_BITS-1:0] len_inc;
    logic                illegal;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign len_inc = len_q + 1'b1;
    assign illegal = (bus.in_data == 8'h24) || (bus.in_data == 8'h2A) ||
                     (bus.in_data == 8'h0D) || (bus.in_data == 8'h0A);

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        csum_d        = csum_q;
        len_d         = len_q;
        last_d        = last_q;
        trunc_d       = trunc_q;
        in_ready      = 1'b0;
        tx_start      = 1'b0;
        err_overlong  = 1'b0;
        err_char      = 1'b0;
        sentence_done = 1'b0;

        case (state_q)
            StIdle: begin
                // Start of sentence is announced before the first byte is consumed
                if (bus.in_valid) begin
                    state_d   = StSendSof;
                    tx_data_d = 8'h24;
                    csum_d    = 8'h00;
                    len_d     = '0;
                    last_d    = 1'b0;
                    trunc_d   = 1'b0;
                end
            end
            StSendSof: begin
                tx_start = 1'b1;
                state_d  = StWaitSof;
            end
            StWaitSof: if (bus.tx_done) state_d = StPayIn;
            StPayIn: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    tx_data_d = bus.in_data;
                    csum_d    = csum_q ^ bus.in_data;
                    len_d     = len_inc;
                    last_d    = bus.in_last;
                    err_char  = illegal;
                    if (len_inc == MaxLen && !bus.in_last) begin
                        err_overlong = 1'b1;
                        trunc_d      = 1'b1;
                    end
                    state_d = StSendPay;
                end
            end
            StSendPay: begin
                tx_start = 1'b1;
                state_d  = StWaitPay;
            end
            StWaitPay: begin
                if (bus.tx_done) begin
                    if (trunc_q) begin
                        state_d = StDrop;
                    end else if (last_q) begin
                        state_d   = StSendStar;
                        tx_data_d = 8'h2A;
                    end else begin
                        state_d = StPayIn;
                    end
                end
            end
            StDrop: begin
                // Discard the remainder of an overlong payload; checksum is left untouched
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_d   = StSendStar;
                    tx_data_d = 8'h2A;
                end
            end
            StSendStar: begin
                tx_start = 1'b1;
                state_d  = StWaitStar;
            end
            StWaitStar: begin
                if (bus.tx_done) begin
                    state_d   = StSendHi;
                    tx_data_d = hex_ascii(csum_q[7:4]);
                end
            end
            StSendHi: begin
                tx_start = 1'b1;
                state_d  = StWaitHi;
            end
            StWaitHi: begin
                if (bus.tx_done) begin
                    state_d   = StSendLo;
                    tx_data_d = hex_ascii(csum_q[3:0]);
                end
            end
            StSendLo: begin
                tx_start = 1'b1;
                state_d  = StWaitLo;
            end
            StWaitLo: begin
                if (bus.tx_done) begin
                    state_d   = StSendCr;
                    tx_data_d = 8'h0D;
                end
            end
            StSendCr: begin
                tx_start = 1'b1;
                state_d  = StWaitCr;
            end
            StWaitCr: begin
                if (bus.tx_done) begin
                    state_d   = StSendLf;
                    tx_data_d = 8'h0A;
                end
            end
            StSendLf: begin
                tx_start = 1'b1;
                state_d  = StWaitLf;
            end
            StWaitLf: begin
                if (bus.tx_done) begin
                    sentence_done = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tx_data_q <= 8'h00;
            csum_q    <= 8'h00;
            len_q     <= '0;
            last_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            csum_q    <= csum_d;
            len_q     <= len_d;
            last_q    <= last_d;
            trunc_q   <= trunc_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Bench for nmea_sentence_tx: directed and random payloads against a sentence-level reference model,
// with a UART transmitter model answering each tx_start.
module tb_nmea_sentence_tx;
    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, sentence_done, err_overlong, err_char;

    nmea_sentence_tx_if ifc ();

    nmea_sentence_tx dut (
        .clk_50MHz    (clk),
        .reset        (rst_n),
        .bus          (ifc),
        .busy         (busy),
        .sentence_done(sentence_done),
        .err_overlong (err_overlong),
        .err_char     (err_char)
    );

    always #10 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    byte_t pl[$];
    byte_t exp_q[$];
    byte_t cap_q[$];
    int    start_cyc_q[$];
    int    sdone_cnt = 0, ovl_cnt = 0, ovl_idx = 0, echar_cnt = 0, acc_cnt = 0;
    int    stab_err = 0, extra_start = 0;
    bit    spur_en = 0, rand_lat = 0;
    int    valid_cyc = 0;
    int    case_base = 0;
    int    exp_ovl, exp_echar;

    always @(posedge clk) cyc++;

    // Transmitter model and output monitor: sample at negedge, answer at posedge + 1
    bit    tx_busy = 0;
    int    tx_cnt  = 0;
    byte_t held    = 8'h00;
    always begin
        @(negedge clk);
        if (rst_n) begin
            if (ifc.tx_start) begin
                if (tx_busy) extra_start++;
                cap_q.push_back(ifc.tx_data);
                start_cyc_q.push_back(cyc);
                held    = ifc.tx_data;
                tx_busy = 1;
                tx_cnt  = rand_lat ? int'($urandom_range(1, 12)) : 10;
            end else if (tx_busy && ifc.tx_data !== held) begin
                stab_err++;
            end
            if (sentence_done) sdone_cnt++;
            if (err_overlong) begin
                ovl_cnt++;
                ovl_idx = acc_cnt + 1;
            end
            if (err_char) echar_cnt++;
            if (ifc.in_valid && ifc.in_ready) acc_cnt++;
        end
        @(posedge clk);
        #1;
        ifc.tx_done = 1'b0;
        if (!rst_n) begin
            tx_busy = 0;
        end else if (tx_busy) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                ifc.tx_done = 1'b1;
                tx_busy     = 0;
            end
        end else if (spur_en && !ifc.tx_start && $urandom_range(0, 3) == 0) begin
            ifc.tx_done = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic load_str(input string s);
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
    endtask

    function automatic byte_t hexc(input int n);
        return (n < 10) ? byte_t'(48 + n) : byte_t'(65 + n - 10);
    endfunction

    // Reference sentence: '$', first 76 payload bytes, '*', XOR checksum in uppercase hex, CR, LF
    task automatic build_expected();
        int    n;
        byte_t cs;
        exp_q.delete();
        cs        = 8'h00;
        n         = (pl.size() > 76) ? 76 : pl.size();
        exp_ovl   = (pl.size() > 76) ? 1 : 0;
        exp_echar = 0;
        exp_q.push_back("$");
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl[i]);
            cs = cs ^ pl[i];
            if (pl[i] == "$" || pl[i] == "*" || pl[i] == 8'h0D || pl[i] == 8'h0A) exp_echar++;
        end
        exp_q.push_back("*");
        exp_q.push_back(hexc(cs / 16));
        exp_q.push_back(hexc(cs % 16));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_payload(input bit gaps, output bit ok);
        bit acc;
        ok = 1;
        for (int i = 0; i < pl.size(); i++) begin
            if (gaps) begin
                ifc.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            ifc.in_data  = pl[i];
            ifc.in_last  = (i == pl.size() - 1);
            ifc.in_valid = 1'b1;
            if (i == 0) valid_cyc = cyc;
            acc = 0;
            for (int t = 0; t < 400 && !acc; t++) begin
                @(negedge clk);
                acc = ifc.in_ready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                ok = 0;
                break;
            end
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic run_case(input string name, input bit gaps);
        int cb, sdb, ovb, ecb, acb, stb, exb, mism;
        bit ok, fin;
        cb  = cap_q.size();
        sdb = sdone_cnt;
        ovb = ovl_cnt;
        ecb = echar_cnt;
        acb = acc_cnt;
        stb = stab_err;
        exb = extra_start;
        case_base = cb;
        build_expected();
        send_payload(gaps, ok);
        check({name, "/accept"}, 32'(ok), 1);
        fin = 0;
        for (int t = 0; t < 6000 && !fin; t++) begin
            @(negedge clk);
            fin = (sdone_cnt > sdb) && !busy;
        end
        check({name, "/finished"}, 32'(fin), 1);
        repeat (4) @(negedge clk);
        check({name, "/n_start"}, cap_q.size() - cb, exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (cb + i >= cap_q.size() || cap_q[cb + i] !== exp_q[i]) mism++;
        check({name, "/byte_mismatches"}, mism, 0);
        check({name, "/sentence_done"}, sdone_cnt - sdb, 1);
        check({name, "/err_overlong"}, ovl_cnt - ovb, exp_ovl);
        check({name, "/err_char"}, echar_cnt - ecb, exp_echar);
        check({name, "/busy_low"}, 32'(busy), 0);
        check({name, "/tx_data_stable"}, stab_err - stb, 0);
        check({name, "/extra_start"}, extra_start - exb, 0);
        if (start_cyc_q.size() > cb) check({name, "/sof_latency"}, start_cyc_q[cb] - valid_cyc, 1);
        if (exp_ovl == 1) check({name, "/overlong_index"}, ovl_idx - acb, 76);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "/outs"}, {26'd0, ifc.tx_start, ifc.in_ready, busy, sentence_done,
                               err_overlong, err_char}, 0);
        check({tag, "/tx_data"}, ifc.tx_data, 0);
    endtask

    initial begin
        byte_t bad[4];
        byte_t b;
        bit    got;
        int    len;
        bad[0] = 8'h24; bad[1] = 8'h2A; bad[2] = 8'h0D; bad[3] = 8'h0A;
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        load_str("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,");
        run_case("ref", 0);
        check("ref/count67", cap_q.size() - case_base, 67);
        if (cap_q.size() >= case_base + 4) begin
            check("ref/hi", cap_q[cap_q.size() - 4], 8'h34);
            check("ref/lo", cap_q[cap_q.size() - 3], 8'h37);
        end

        load_str("A");
        run_case("single", 0);
        load_str("A*");
        run_case("illegal", 0);

        pl.delete();
        for (int i = 0; i < 80; i++) pl.push_back(8'h58);
        run_case("overlong", 0);

        // Reset while a payload byte is in flight at the transmitter
        ifc.in_data  = "Z";
        ifc.in_last  = 1'b0;
        ifc.in_valid = 1'b1;
        len = cap_q.size();
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = (cap_q.size() >= len + 2);
        end
        check("midreset/reach_wait_pay", 32'(got), 1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n        = 1'b0;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        load_str("B");
        run_case("after_reset", 0);

        spur_en  = 1;
        rand_lat = 1;
        load_str("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,");
        run_case("ref_gaps", 1);

        for (int k = 0; k < 7; k++) begin
            len = (k == 6) ? 85 : int'($urandom_range(1, 24));
            pl.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    b = bad[$urandom_range(0, 3)];
                end else begin
                    do b = 8'($urandom_range(32, 126)); while (b == 8'h24 || b == 8'h2A);
                end
                pl.push_back(b);
            end
            run_case($sformatf("rand%0d", k), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
